otter_ex_branch_ctrl: RTL and testbench

- Execute-stage consumer of the OTTER pipeline decoder's control stream. Takes over the branch-condition and PC-source generation that moved out of decode.
- Resolves branches, JAL, JALR, MRET and interrupts in EX, and drives the PC mux select.
- Squashes wrong-path instructions for a fixed window after every redirect, using a small flush state machine.
- Sits between the ID/EX pipeline register and the IF-stage PC mux.

---
 rtl/otter_pkg.sv | 43 ++++
 rtl/otter_branch_cond_gen.sv | 31 +++
 rtl/otter_ex_branch_ctrl.sv | 125 ++++++++++++
 tb/tb_otter_ex_branch_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER encodings: opcodes, branch func3 codes, PC mux selects and the
// EX-stage flush FSM states.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func3_t;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pcsrc_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  localparam logic [2:0] FUNC3_PRIV = 3'b000;

endpackage

// File: rtl/otter_branch_cond_gen.sv
// Combinational branch-condition evaluator; unknown func3 codes are not taken.
module otter_branch_cond_gen
  import otter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  output logic            taken
);

  logic eq, lt, ltu;

  always_comb begin
    eq  = (rs1 == rs2);
    lt  = ($signed(rs1) < $signed(rs2));
    ltu = (rs1 < rs2);
    taken = 1'b0;
    case (func3)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = ~lt;
      BR_BLTU: taken = ltu;
      BR_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_ex_branch_ctrl.sv
// EX-stage redirect/flush controller for the OTTER pipeline.
// Optional branch statistics counters are enabled with OTTER_BR_STATS_EN.
module otter_ex_branch_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EX_VALID,
  input  logic            EX_STALL,
  input  logic [6:0]      EX_OPCODE,
  input  logic [2:0]      EX_FUNC3,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [XLEN-1:0] EX_RS1,
  input  logic [XLEN-1:0] EX_RS2,
  input  logic            INT_REQ,
  input  logic            INT_EN,
  output logic [2:0]      PC_SOURCE,
  output logic            REDIRECT,
  output logic            EX_KILL,
  output logic            INT_TAKEN,
  output logic [XLEN-1:0] INT_EPC
`ifdef OTTER_BR_STATS_EN
  ,
  output logic [31:0]     BR_TOTAL_CNT,
  output logic [31:0]     BR_TAKEN_CNT
`endif
);

  flush_state_t state;
  logic [2:0]   cnt;
  logic         int_pending;
  logic         cond_taken;
  logic         live;
  logic         take_int;
  logic         is_branch;
  pcsrc_t       pc_sel;

  otter_branch_cond_gen #(.XLEN(XLEN)) u_cond (
    .rs1   (EX_RS1),
    .rs2   (EX_RS2),
    .func3 (EX_FUNC3),
    .taken (cond_taken)
  );

  // RST gates every output so the mux sees pc+4 while reset is held.
  always_comb begin
    live      = EX_VALID & ~EX_STALL & (state == ST_RUN);
    is_branch = (EX_OPCODE == OPC_BRANCH);
    pc_sel    = PC_PLUS4;
    take_int  = 1'b0;
    if (!RST && live) begin
      if (int_pending) begin
        pc_sel   = PC_MTVEC;
        take_int = 1'b1;
      end else if (EX_OPCODE == OPC_JAL) begin
        pc_sel = PC_JAL;
      end else if (EX_OPCODE == OPC_JALR) begin
        pc_sel = PC_JALR;
      end else if (is_branch && cond_taken) begin
        pc_sel = PC_BRANCH;
      end else if (EX_OPCODE == OPC_SYSTEM && EX_FUNC3 == FUNC3_PRIV) begin
        pc_sel = PC_MEPC;
      end
    end
    PC_SOURCE = pc_sel;
    REDIRECT  = (pc_sel != PC_PLUS4);
    INT_TAKEN = take_int;
    INT_EPC   = take_int ? EX_PC : '0;
    EX_KILL   = ~RST & (take_int | ((state == ST_FLUSH) & EX_VALID));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RUN;
      cnt         <= '0;
      int_pending <= 1'b0;
    end else begin
      if (take_int || !INT_EN) begin
        int_pending <= 1'b0;
      end else if (INT_REQ) begin
        int_pending <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (REDIRECT) begin
            state <= ST_FLUSH;
            cnt   <= 3'(FLUSH_CYCLES);
          end
        end
        ST_FLUSH: begin
          if (!EX_STALL) begin
            if (cnt <= 3'd1) begin
              state <= ST_RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef OTTER_BR_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      BR_TOTAL_CNT <= '0;
      BR_TAKEN_CNT <= '0;
    end else if (live && is_branch) begin
      BR_TOTAL_CNT <= BR_TOTAL_CNT + 32'd1;
      if (cond_taken) begin
        BR_TAKEN_CNT <= BR_TAKEN_CNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_otter_ex_branch_ctrl.sv
// Directed bench for otter_ex_branch_ctrl (FLUSH_CYCLES=2, XLEN=32).
// Statistics checks compile in only when OTTER_BR_STATS_EN is defined.
module tb_otter_ex_branch_ctrl;
  import otter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2;
  logic        int_req, int_en;
  logic [2:0]  pc_source;
  logic        redirect, ex_kill, int_taken;
  logic [31:0] int_epc;
`ifdef OTTER_BR_STATS_EN
  logic [31:0] br_total_cnt, br_taken_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  otter_ex_branch_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .CLK       (clk),
    .RST       (rst),
    .EX_VALID  (ex_valid),
    .EX_STALL  (ex_stall),
    .EX_OPCODE (ex_opcode),
    .EX_FUNC3  (ex_func3),
    .EX_PC     (ex_pc),
    .EX_RS1    (ex_rs1),
    .EX_RS2    (ex_rs2),
    .INT_REQ   (int_req),
    .INT_EN    (int_en),
    .PC_SOURCE (pc_source),
    .REDIRECT  (redirect),
    .EX_KILL   (ex_kill),
    .INT_TAKEN (int_taken),
    .INT_EPC   (int_epc)
`ifdef OTTER_BR_STATS_EN
    ,
    .BR_TOTAL_CNT (br_total_cnt),
    .BR_TAKEN_CNT (br_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic s, input logic [6:0] op,
                     input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] a, input logic [31:0] b);
    ex_valid  = v;
    ex_stall  = s;
    ex_opcode = op;
    ex_func3  = f3;
    ex_pc     = pc;
    ex_rs1    = a;
    ex_rs2    = b;
  endtask

  task automatic bubble();
    drv(1'b0, 1'b0, OPC_OP, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  // Samples outputs on the falling edge, then steps to just past the next rising edge.
  task automatic chk(input string tag, input logic [2:0] ps, input logic red,
                     input logic kill, input logic it, input logic [31:0] epc);
    @(negedge clk);
    n_vec++;
    assert (pc_source === ps) else begin
      n_err++; $error("FAIL %s pc_source got %0d exp %0d", tag, pc_source, ps);
    end
    n_vec++;
    assert (redirect === red) else begin
      n_err++; $error("FAIL %s redirect got %b exp %b", tag, redirect, red);
    end
    n_vec++;
    assert (ex_kill === kill) else begin
      n_err++; $error("FAIL %s ex_kill got %b exp %b", tag, ex_kill, kill);
    end
    n_vec++;
    assert (int_taken === it) else begin
      n_err++; $error("FAIL %s int_taken got %b exp %b", tag, int_taken, it);
    end
    n_vec++;
    assert (int_epc === epc) else begin
      n_err++; $error("FAIL %s int_epc got %h exp %h", tag, int_epc, epc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; int_req = 1'b0; int_en = 1'b0;
    drv(1'b1, 1'b0, OPC_JAL, 3'b000, 32'h10, 32'h0, 32'h0);
    chk("rst_held", 3'd0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    bubble();
    chk("post_rst", 3'd0, 0, 0, 0, 32'h0);

    // Taken BEQ, two killed cycles (JAL inside flush ignored), back to RUN
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BEQ, 32'h100, 32'h5, 32'h5);
    chk("beq_taken", 3'd2, 1, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_JAL, 3'b000, 32'h104, 32'h0, 32'h0);
    chk("flush1_jal", 3'd0, 0, 1, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h108, 32'h0, 32'h0);
    chk("flush2", 3'd0, 0, 1, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h10c, 32'h0, 32'h0);
    chk("run_again", 3'd0, 0, 0, 0, 32'h0);

    // Signed vs unsigned compare; bubbles inside flush are not killed
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BLT, 32'h110, 32'hFFFF_FFFF, 32'h1);
    chk("blt_neg", 3'd2, 1, 0, 0, 32'h0);
    bubble();
    chk("flush_bubble1", 3'd0, 0, 0, 0, 32'h0);
    bubble();
    chk("flush_bubble2", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BLTU, 32'h120, 32'hFFFF_FFFF, 32'h1);
    chk("bltu_nt", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_BRANCH, 3'b010, 32'h124, 32'h7, 32'h7);
    chk("bad_func3", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_SYSTEM, FUNC3_PRIV, 32'h128, 32'h0, 32'h0);
    chk("mret", 3'd5, 1, 0, 0, 32'h0);
    bubble();
    chk("mret_fl1", 3'd0, 0, 0, 0, 32'h0);
    bubble();
    chk("mret_fl2", 3'd0, 0, 0, 0, 32'h0);

    // Interrupt latched on a bubble, waits through a bubble, beats JAL
    int_en = 1'b1; int_req = 1'b1;
    bubble();
    chk("int_req_bubble", 3'd0, 0, 0, 0, 32'h0);
    int_req = 1'b0;
    bubble();
    chk("int_wait_bubble", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_JAL, 3'b000, 32'h200, 32'h0, 32'h0);
    chk("int_over_jal", 3'd4, 1, 1, 1, 32'h200);
    bubble();
    chk("int_fl1", 3'd0, 0, 0, 0, 32'h0);
    bubble();
    chk("int_fl2", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h204, 32'h0, 32'h0);
    chk("int_cleared", 3'd0, 0, 0, 0, 32'h0);

    // Dropping INT_EN discards a pending interrupt
    int_req = 1'b1;
    bubble();
    chk("int_set2", 3'd0, 0, 0, 0, 32'h0);
    int_req = 1'b0; int_en = 1'b0;
    bubble();
    chk("int_en_drop", 3'd0, 0, 0, 0, 32'h0);
    int_en = 1'b1;
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h208, 32'h0, 32'h0);
    chk("int_discarded", 3'd0, 0, 0, 0, 32'h0);

    // Interrupt and taken branch together: interrupt wins with the branch PC
    int_req = 1'b1;
    bubble();
    chk("int_set3", 3'd0, 0, 0, 0, 32'h0);
    int_req = 1'b0;
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BEQ, 32'h400, 32'h9, 32'h9);
    chk("int_over_br", 3'd4, 1, 1, 1, 32'h400);
    bubble();
    chk("ib_fl1", 3'd0, 0, 0, 0, 32'h0);
    bubble();
    chk("ib_fl2", 3'd0, 0, 0, 0, 32'h0);

    // JALR stalled three cycles, then a stall freezes the flush counter
    drv(1'b1, 1'b1, OPC_JALR, 3'b000, 32'h300, 32'h0, 32'h0);
    chk("jalr_stall1", 3'd0, 0, 0, 0, 32'h0);
    chk("jalr_stall2", 3'd0, 0, 0, 0, 32'h0);
    chk("jalr_stall3", 3'd0, 0, 0, 0, 32'h0);
    ex_stall = 1'b0;
    chk("jalr_go", 3'd1, 1, 0, 0, 32'h0);
    drv(1'b1, 1'b1, OPC_OP, 3'b000, 32'h304, 32'h0, 32'h0);
    chk("fl_stalled", 3'd0, 0, 1, 0, 32'h0);
    ex_stall = 1'b0;
    chk("fl_a", 3'd0, 0, 1, 0, 32'h0);
    chk("fl_b", 3'd0, 0, 1, 0, 32'h0);
    chk("fl_done", 3'd0, 0, 0, 0, 32'h0);

    // Reset during the second flush cycle (stalled, interrupt pending)
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BEQ, 32'h500, 32'h3, 32'h3);
    chk("rb_br", 3'd2, 1, 0, 0, 32'h0);
    int_req = 1'b1;
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h504, 32'h0, 32'h0);
    chk("rb_fl1", 3'd0, 0, 1, 0, 32'h0);
    int_req = 1'b0; rst = 1'b1;
    drv(1'b1, 1'b1, OPC_JAL, 3'b000, 32'h508, 32'h0, 32'h0);
    chk("rb_rst_fl2", 3'd0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    drv(1'b1, 1'b0, OPC_OP, 3'b000, 32'h50c, 32'h0, 32'h0);
    chk("rb_after", 3'd0, 0, 0, 0, 32'h0);
    drv(1'b1, 1'b0, OPC_BRANCH, BR_BNE, 32'h600, 32'h1, 32'h2);
    chk("rb_bne", 3'd2, 1, 0, 0, 32'h0);
    bubble();
    chk("rb_bne_fl1", 3'd0, 0, 0, 0, 32'h0);
    bubble();
    chk("rb_bne_fl2", 3'd0, 0, 0, 0, 32'h0);

`ifdef OTTER_BR_STATS_EN
    rst = 1'b1;
    bubble();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    assert (br_total_cnt === 32'd0 && br_taken_cnt === 32'd0) else begin
      n_err++; $error("FAIL stats_rst got %0d/%0d exp 0/0", br_total_cnt, br_taken_cnt);
    end
    @(posedge clk); #1;
    // Four taken, one inside flush (uncounted), five not taken: 10 branches in total
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, OPC_BRANCH, BR_BEQ, 32'h700, 32'h1, 32'h1);
      @(posedge clk); #1;
      if (i == 0) drv(1'b1, 1'b0, OPC_BRANCH, BR_BNE, 32'h704, 32'h1, 32'h1);
      else bubble();
      @(posedge clk); #1;
      bubble();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, OPC_BRANCH, BR_BNE, 32'h710, 32'h4, 32'h4);
      @(posedge clk); #1;
    end
    bubble();
    @(negedge clk);
    n_vec++;
    assert (br_total_cnt === 32'd9) else begin
      n_err++; $error("FAIL stats_total got %0d exp 9", br_total_cnt);
    end
    n_vec++;
    assert (br_taken_cnt === 32'd4) else begin
      n_err++; $error("FAIL stats_taken got %0d exp 4", br_taken_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
